// File: rtl/hazard_interlock_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_interlock_unit
// Purpose  : Stall/flush interlock for a 5-stage MIPS pipeline. It handles
//            load-use, branch-operand, taken-branch flush and dmem freeze.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_interlock_unit #(
    parameter int LOAD_BRANCH_STALLS = 2,
    parameter int COUNT_W            = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [4:0]         IFIDRs_i,
    input  logic [4:0]         IFIDRt_i,
    input  logic               IDUsesRs_i,
    input  logic               IDUsesRt_i,
    input  logic               IDIsBranch_i,
    input  logic               BranchTaken_i,
    input  logic               IDEXMemRead_i,
    input  logic               IDEXRegWrite_i,
    input  logic [4:0]         IDEXWriteReg_i,
    input  logic               EXMEMMemRead_i,
    input  logic               EXMEMRegWrite_i,
    input  logic [4:0]         EXMEMRd_i,
    input  logic               DMemBusy_i,
    output logic               PCWrite_o,
    output logic               IFIDWrite_o,
    output logic               IFIDFlush_o,
    output logic               IDEXBubble_o,
    output logic               PipeFreeze_o,
    output logic [COUNT_W-1:0] StallCycles_o,
    output logic [COUNT_W-1:0] FlushCount_o
);

    typedef enum logic [0:0] {RUN = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [1:0]         c_LB_STALLS = LOAD_BRANCH_STALLS[1:0];
    localparam logic [COUNT_W-1:0] c_CNT_MAX   = {COUNT_W{1'b1}};

    state_t             state_q, state_d;
    logic [1:0]         rem_q, rem_d;
    logic [COUNT_W-1:0] stall_cnt_q, flush_cnt_q;

    logic w_match_ex, w_match_mem;
    logic w_h_lu, w_h_lb, w_h_ab, w_h_mb;
    logic [1:0] w_n_req;

    assign w_match_ex  = (IDEXWriteReg_i != 5'd0) &&
                         ((IDUsesRs_i && (IFIDRs_i == IDEXWriteReg_i)) ||
                          (IDUsesRt_i && (IFIDRt_i == IDEXWriteReg_i)));
    assign w_match_mem = (EXMEMRd_i != 5'd0) &&
                         ((IDUsesRs_i && (IFIDRs_i == EXMEMRd_i)) ||
                          (IDUsesRt_i && (IFIDRt_i == EXMEMRd_i)));

    assign w_h_lu = IDEXMemRead_i && IDEXRegWrite_i && w_match_ex && !IDIsBranch_i;
    assign w_h_lb = IDIsBranch_i && IDEXMemRead_i && IDEXRegWrite_i && w_match_ex;
    assign w_h_ab = IDIsBranch_i && !IDEXMemRead_i && IDEXRegWrite_i && w_match_ex;
    assign w_h_mb = IDIsBranch_i && EXMEMMemRead_i && EXMEMRegWrite_i && w_match_mem;

    // Load-to-branch needs the longest stall, so it dominates the others.
    assign w_n_req = w_h_lb ? c_LB_STALLS :
                     (w_h_lu || w_h_ab || w_h_mb) ? 2'd1 : 2'd0;

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        PCWrite_o    = 1'b1;
        IFIDWrite_o  = 1'b1;
        IFIDFlush_o  = 1'b0;
        IDEXBubble_o = 1'b0;
        PipeFreeze_o = 1'b0;
        if (reset_i) begin
            state_d = RUN;
            rem_d   = 2'd0;
        end else if (DMemBusy_i) begin
            PipeFreeze_o = 1'b1;
            PCWrite_o    = 1'b0;
            IFIDWrite_o  = 1'b0;
        end else if (state_q == HOLD) begin
            PCWrite_o    = 1'b0;
            IFIDWrite_o  = 1'b0;
            IDEXBubble_o = 1'b1;
            rem_d        = rem_q - 2'd1;
            if (rem_q == 2'd1) begin
                state_d = RUN;
            end
        end else if (w_n_req != 2'd0) begin
            PCWrite_o    = 1'b0;
            IFIDWrite_o  = 1'b0;
            IDEXBubble_o = 1'b1;
            if (w_n_req > 2'd1) begin
                state_d = HOLD;
                rem_d   = w_n_req - 2'd1;
            end
        end else begin
            IFIDFlush_o = BranchTaken_i && IDIsBranch_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= RUN;
            rem_q       <= 2'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            if (IDEXBubble_o && (stall_cnt_q != c_CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (IFIDFlush_o && (flush_cnt_q != c_CNT_MAX)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign StallCycles_o = stall_cnt_q;
    assign FlushCount_o  = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_interlock_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_interlock_unit
// Purpose  : Directed self-checking bench for hazard_interlock_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_interlock_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] IFIDRs, IFIDRt, IDEXWriteReg, EXMEMRd;
    logic       IDUsesRs, IDUsesRt, IDIsBranch, BranchTaken;
    logic       IDEXMemRead, IDEXRegWrite, EXMEMMemRead, EXMEMRegWrite, DMemBusy;
    logic       PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, PipeFreeze;
    logic [31:0] StallCycles, FlushCount;
    logic       s_PCWrite, s_IFIDWrite, s_IFIDFlush, s_IDEXBubble, s_PipeFreeze;
    logic [1:0] s_StallCycles, s_FlushCount;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_interlock_unit #(.LOAD_BRANCH_STALLS(2), .COUNT_W(32)) dut (
        .clk_i(clk), .reset_i(reset),
        .IFIDRs_i(IFIDRs), .IFIDRt_i(IFIDRt),
        .IDUsesRs_i(IDUsesRs), .IDUsesRt_i(IDUsesRt),
        .IDIsBranch_i(IDIsBranch), .BranchTaken_i(BranchTaken),
        .IDEXMemRead_i(IDEXMemRead), .IDEXRegWrite_i(IDEXRegWrite),
        .IDEXWriteReg_i(IDEXWriteReg),
        .EXMEMMemRead_i(EXMEMMemRead), .EXMEMRegWrite_i(EXMEMRegWrite),
        .EXMEMRd_i(EXMEMRd), .DMemBusy_i(DMemBusy),
        .PCWrite_o(PCWrite), .IFIDWrite_o(IFIDWrite), .IFIDFlush_o(IFIDFlush),
        .IDEXBubble_o(IDEXBubble), .PipeFreeze_o(PipeFreeze),
        .StallCycles_o(StallCycles), .FlushCount_o(FlushCount)
    );

    // Narrow-counter instance sharing all inputs, used for saturation.
    hazard_interlock_unit #(.LOAD_BRANCH_STALLS(2), .COUNT_W(2)) dut_small (
        .clk_i(clk), .reset_i(reset),
        .IFIDRs_i(IFIDRs), .IFIDRt_i(IFIDRt),
        .IDUsesRs_i(IDUsesRs), .IDUsesRt_i(IDUsesRt),
        .IDIsBranch_i(IDIsBranch), .BranchTaken_i(BranchTaken),
        .IDEXMemRead_i(IDEXMemRead), .IDEXRegWrite_i(IDEXRegWrite),
        .IDEXWriteReg_i(IDEXWriteReg),
        .EXMEMMemRead_i(EXMEMMemRead), .EXMEMRegWrite_i(EXMEMRegWrite),
        .EXMEMRd_i(EXMEMRd), .DMemBusy_i(DMemBusy),
        .PCWrite_o(s_PCWrite), .IFIDWrite_o(s_IFIDWrite), .IFIDFlush_o(s_IFIDFlush),
        .IDEXBubble_o(s_IDEXBubble), .PipeFreeze_o(s_PipeFreeze),
        .StallCycles_o(s_StallCycles), .FlushCount_o(s_FlushCount)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        IFIDRs = 5'd0; IFIDRt = 5'd0; IDEXWriteReg = 5'd0; EXMEMRd = 5'd0;
        IDUsesRs = 1'b0; IDUsesRt = 1'b0; IDIsBranch = 1'b0; BranchTaken = 1'b0;
        IDEXMemRead = 1'b0; IDEXRegWrite = 1'b0;
        EXMEMMemRead = 1'b0; EXMEMRegWrite = 1'b0; DMemBusy = 1'b0;
    endtask

    task automatic clear_idex();
        IDEXMemRead = 1'b0; IDEXRegWrite = 1'b0; IDEXWriteReg = 5'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        step();
        step();
        reset = 1'b0;
    endtask

    // Load in EX writing $3, beq in ID reading $3 through rt.
    task automatic set_load_branch();
        IDEXMemRead = 1'b1; IDEXRegWrite = 1'b1; IDEXWriteReg = 5'd3;
        IDIsBranch = 1'b1; IDUsesRt = 1'b1; IFIDRt = 5'd3;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        IDEXMemRead = 1'b1; IDEXRegWrite = 1'b1; IDEXWriteReg = 5'd2;
        IDUsesRs = 1'b1; IFIDRs = 5'd2;
        @(negedge clk);
        n_checks++;
        if ({PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, PipeFreeze} !== 5'b11000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 11000",
                     {PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, PipeFreeze});
        end
        step();
        reset = 1'b0;
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (StallCycles !== 32'd0 || FlushCount !== 32'd0 || PCWrite !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_counters: got stall=%0d flush=%0d pcw=%b want 0 0 1",
                     StallCycles, FlushCount, PCWrite);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        IDEXMemRead = 1'b1; IDEXRegWrite = 1'b1; IDEXWriteReg = 5'd2;
        IDUsesRs = 1'b1; IFIDRs = 5'd2;
        @(negedge clk);
        n_checks++;
        if ({PCWrite, IFIDWrite, IDEXBubble} !== 3'b001) begin
            n_fail++;
            $display("FAIL load_use_stall: got pcw/ifw/bub=%b want 001",
                     {PCWrite, IFIDWrite, IDEXBubble});
        end
        step();
        clear_idex();
        @(negedge clk);
        n_checks++;
        if (PCWrite !== 1'b1 || IDEXBubble !== 1'b0 || StallCycles !== 32'd1) begin
            n_fail++;
            $display("FAIL load_use_release: got pcw=%b bub=%b stall=%0d want 1 0 1",
                     PCWrite, IDEXBubble, StallCycles);
        end
    endtask

    task automatic test_load_branch();
        do_reset();
        set_load_branch();
        @(negedge clk);
        n_checks++;
        if (IDEXBubble !== 1'b1 || PCWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL load_branch_c1: got bub=%b pcw=%b want 1 0", IDEXBubble, PCWrite);
        end
        step();
        clear_idex();
        @(negedge clk);
        n_checks++;
        if (IDEXBubble !== 1'b1 || PCWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL load_branch_c2: got bub=%b pcw=%b want 1 0", IDEXBubble, PCWrite);
        end
        step();
        @(negedge clk);
        n_checks++;
        if (IDEXBubble !== 1'b0 || PCWrite !== 1'b1 || StallCycles !== 32'd2) begin
            n_fail++;
            $display("FAIL load_branch_end: got bub=%b pcw=%b stall=%0d want 0 1 2",
                     IDEXBubble, PCWrite, StallCycles);
        end
    endtask

    task automatic test_no_hazard();
        do_reset();
        IDEXMemRead = 1'b1; IDEXRegWrite = 1'b1; IDEXWriteReg = 5'd0;
        IDUsesRs = 1'b1; IFIDRs = 5'd0;
        @(negedge clk);
        n_checks++;
        if (IDEXBubble !== 1'b0 || PCWrite !== 1'b1) begin
            n_fail++;
            $display("FAIL r0_no_stall: got bub=%b pcw=%b want 0 1", IDEXBubble, PCWrite);
        end
        step();
        IDEXMemRead = 1'b0; IDEXWriteReg = 5'd4; IFIDRs = 5'd4;
        @(negedge clk);
        n_checks++;
        if (IDEXBubble !== 1'b0 || PCWrite !== 1'b1) begin
            n_fail++;
            $display("FAIL alu_no_stall: got bub=%b pcw=%b want 0 1", IDEXBubble, PCWrite);
        end
        step();
        clear_inputs();
        IDIsBranch = 1'b1; IDUsesRs = 1'b1; IFIDRs = 5'd5;
        EXMEMMemRead = 1'b1; EXMEMRegWrite = 1'b1; EXMEMRd = 5'd5;
        @(negedge clk);
        n_checks++;
        if (IDEXBubble !== 1'b1) begin
            n_fail++;
            $display("FAIL mem_branch_stall: got bub=%b want 1", IDEXBubble);
        end
        step();
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (IDEXBubble !== 1'b0 || StallCycles !== 32'd1) begin
            n_fail++;
            $display("FAIL mem_branch_one: got bub=%b stall=%0d want 0 1", IDEXBubble, StallCycles);
        end
    endtask

    task automatic test_freeze();
        do_reset();
        set_load_branch();
        step();
        clear_idex();
        DMemBusy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({PipeFreeze, PCWrite, IFIDWrite, IDEXBubble, IFIDFlush} !== 5'b10000
                || StallCycles !== 32'd1) begin
                n_fail++;
                $display("FAIL freeze_c%0d: got frz/pcw/ifw/bub/fl=%b stall=%0d want 10000 1",
                         i, {PipeFreeze, PCWrite, IFIDWrite, IDEXBubble, IFIDFlush}, StallCycles);
            end
            step();
        end
        DMemBusy = 1'b0;
        @(negedge clk);
        n_checks++;
        if (IDEXBubble !== 1'b1 || PipeFreeze !== 1'b0) begin
            n_fail++;
            $display("FAIL freeze_resume_stall: got bub=%b frz=%b want 1 0", IDEXBubble, PipeFreeze);
        end
        step();
        @(negedge clk);
        n_checks++;
        if (IDEXBubble !== 1'b0 || StallCycles !== 32'd2) begin
            n_fail++;
            $display("FAIL freeze_end: got bub=%b stall=%0d want 0 2", IDEXBubble, StallCycles);
        end
    endtask

    task automatic test_flush();
        do_reset();
        IDIsBranch = 1'b1; BranchTaken = 1'b1; IDUsesRs = 1'b1; IFIDRs = 5'd6;
        @(negedge clk);
        n_checks++;
        if (IFIDFlush !== 1'b1 || PCWrite !== 1'b1 || IDEXBubble !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_taken: got fl=%b pcw=%b bub=%b want 1 1 0",
                     IFIDFlush, PCWrite, IDEXBubble);
        end
        step();
        IDEXRegWrite = 1'b1; IDEXWriteReg = 5'd6;
        @(negedge clk);
        n_checks++;
        if (IFIDFlush !== 1'b0 || IDEXBubble !== 1'b1 || FlushCount !== 32'd1) begin
            n_fail++;
            $display("FAIL flush_suppressed: got fl=%b bub=%b fcnt=%0d want 0 1 1",
                     IFIDFlush, IDEXBubble, FlushCount);
        end
        step();
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (FlushCount !== 32'd1 || StallCycles !== 32'd1) begin
            n_fail++;
            $display("FAIL flush_counts: got fcnt=%0d stall=%0d want 1 1", FlushCount, StallCycles);
        end
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        set_load_branch();
        step();
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        n_checks++;
        if (IDEXBubble !== 1'b0 || PCWrite !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_reset_outputs: got bub=%b pcw=%b want 0 1", IDEXBubble, PCWrite);
        end
        step();
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (IDEXBubble !== 1'b0 || PCWrite !== 1'b1 || StallCycles !== 32'd0) begin
            n_fail++;
            $display("FAIL hold_reset_run: got bub=%b pcw=%b stall=%0d want 0 1 0",
                     IDEXBubble, PCWrite, StallCycles);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        IDEXMemRead = 1'b1; IDEXRegWrite = 1'b1; IDEXWriteReg = 5'd7;
        IDUsesRt = 1'b1; IFIDRt = 5'd7;
        for (int k = 1; k <= 5; k++) begin
            step();
            @(negedge clk);
            n_checks++;
            if (s_StallCycles !== ((k > 3) ? 2'd3 : 2'(k)) || StallCycles !== 32'(k)) begin
                n_fail++;
                $display("FAIL saturate_k%0d: got small=%0d wide=%0d want %0d %0d",
                         k, s_StallCycles, StallCycles, (k > 3) ? 3 : k, k);
            end
        end
        clear_inputs();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_load_branch();
        test_no_hazard();
        test_freeze();
        test_flush();
        test_reset_in_hold();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
